// File: rtl/pdm_modulator_if.sv
// PCM sample stream into the PDM modulator: 8-bit sample with valid/ready.
// The source drives din/din_valid; the modulator answers with din_ready.
interface pdm_modulator_if;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;

    modport master (output din, output din_valid, input din_ready);
    modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/pdm_modulator.sv
// pdm_modulator: 8-bit PCM in, 1-bit PDM out.
// Samples enter a small FIFO, each is held for OSR clocks and fed to a
// first-order delta-sigma modulator (carry-out of an 8-bit accumulator).
// Optional macro PDM_DITHER_EN adds a 16-bit LFSR bit as accumulator carry-in.
module pdm_modulator #(
    parameter int OSR        = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int LW         = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            clr_underrun,
    pdm_modulator_if.slave  s,
    output logic            out,
    output logic            sample_strobe,
    output logic            underrun,
    output logic [LW-1:0]   fifo_level
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int PW = (OSR > 1) ? $clog2(OSR) : 1;

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    state_t          state, state_nxt;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wptr, rptr;
    logic            ready_q;
    logic [LW-1:0]   level_nxt;
    logic            wr, pop, step, boundary, not_empty, underrun_set;
    logic [7:0]      acc, cur;
    logic [PW-1:0]   phase;
    logic [8:0]      sum;
    logic            d;

    assign s.din_ready = ready_q;
    assign wr          = s.din_valid && ready_q;
    // Reads look only at the registered level, so a write landing in the
    // same cycle cannot be popped before it is actually stored.
    assign not_empty   = (fifo_level != '0);
    assign boundary    = (phase == PW'(OSR - 1));
    assign level_nxt   = fifo_level + LW'(wr) - LW'(pop);

    // Modulator sum: carry out is the PDM bit, low byte is the new error.
    assign sum = {1'b0, acc} + {1'b0, cur} + {8'd0, d};

`ifdef PDM_DITHER_EN
    logic [15:0] lfsr;

    // Fibonacci LFSR (taps 16,14,13,11) stepping only while modulating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            lfsr <= 16'hACE1;
        else if (step)
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign d = lfsr[0];
`else
    assign d = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state plus per-cycle control: pop, modulator step, underrun event.
    always_comb begin
        state_nxt    = state;
        pop          = 1'b0;
        step         = 1'b0;
        underrun_set = 1'b0;
        case (state)
            IDLE: begin
                if (en) state_nxt = PRIME;
            end
            PRIME: begin
                if (!en) begin
                    state_nxt = IDLE;
                end else if (not_empty) begin
                    pop       = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!en) begin
                    state_nxt = IDLE;
                end else begin
                    step = 1'b1;
                    if (boundary) begin
                        pop          = not_empty;
                        underrun_set = !not_empty;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FIFO storage; no reset needed since the level gates every read.
    always_ff @(posedge clk) begin
        if (wr) mem[wptr] <= s.din;
    end

    // FIFO pointers, level and registered ready from the post-update level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_level <= '0;
            ready_q    <= 1'b1;
        end else begin
            if (wr)  wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            fifo_level <= level_nxt;
            ready_q    <= (level_nxt < LW'(FIFO_DEPTH));
        end
    end

    // Sample hold, phase counter and accumulator; acc survives boundaries
    // and is only cleared outside RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc           <= '0;
            out           <= 1'b0;
            cur           <= 8'h80;
            phase         <= '0;
            sample_strobe <= 1'b0;
        end else begin
            sample_strobe <= pop;
            if (pop) cur <= mem[rptr];
            if (step) begin
                acc   <= sum[7:0];
                out   <= sum[8];
                phase <= boundary ? '0 : phase + 1'b1;
            end else begin
                acc   <= '0;
                out   <= 1'b0;
                phase <= '0;
            end
        end
    end

    // Sticky underrun; a new event beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)               underrun <= 1'b0;
        else if (underrun_set) underrun <= 1'b1;
        else if (clr_underrun) underrun <= 1'b0;
    end

endmodule

// File: tb/tb_pdm_modulator.sv
// Bench for pdm_modulator: directed stimulus, a cumulative-sum reference
// model compared every negedge, and hand-computed literal expectations.
module tb_pdm_modulator;
    localparam int OSR = 16, DEPTH = 4, LW = 3;

    logic clk = 1'b0, rst = 1'b1, en = 1'b0, clr = 1'b0;
    logic out, strobe, under;
    logic [LW-1:0] level;

    pdm_modulator_if ifc();

    always #5 clk = ~clk;

    pdm_modulator #(.OSR(OSR), .FIFO_DEPTH(DEPTH), .LW(LW)) dut (
        .clk(clk), .rst(rst), .en(en), .clr_underrun(clr), .s(ifc.slave),
        .out(out), .sample_strobe(strobe), .underrun(under), .fifo_level(level));

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the PDM bit is whether the running total of all
    // samples fed since entering RUN crossed a multiple of 256 this clock.
    byte unsigned q[$];
    bit          m_ready, m_out, m_strobe, m_under;
    int          m_mode, m_cnt, m_cur;
    longint      m_total;
    logic [15:0] m_lfsr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_ready = 1; m_out = 0; m_strobe = 0; m_under = 0;
            m_mode = 0; m_cnt = 0; m_cur = 128; m_total = 0; m_lfsr = 16'hACE1;
        end else begin
            bit wr, setu;
            longint nt;
            int d;
            wr = ifc.din_valid && m_ready;
            setu = 0; m_strobe = 0; d = 0;
            case (m_mode)
                0: begin
                    m_out = 0; m_total = 0;
                    if (en) m_mode = 1;
                end
                1: begin
                    if (!en) m_mode = 0;
                    else if (q.size() > 0) begin
                        m_cur = q.pop_front(); m_strobe = 1;
                        m_cnt = 0; m_total = 0; m_mode = 2;
                    end
                end
                default: begin
                    if (!en) begin
                        m_mode = 0; m_out = 0; m_total = 0;
                    end else begin
`ifdef PDM_DITHER_EN
                        d = m_lfsr[0];
                        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
`endif
                        nt = m_total + m_cur + d;
                        m_out = ((nt / 256) != (m_total / 256));
                        m_total = nt;
                        if (m_cnt == OSR - 1) begin
                            m_cnt = 0;
                            if (q.size() > 0) begin m_cur = q.pop_front(); m_strobe = 1; end
                            else setu = 1;
                        end else m_cnt++;
                    end
                end
            endcase
            if (setu) m_under = 1;
            else if (clr) m_under = 0;
            if (wr) q.push_back(ifc.din);
            m_ready = (q.size() < DEPTH);
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("out", 32'(out), 32'(m_out));
            chk("strobe", 32'(strobe), 32'(m_strobe));
            chk("underrun", 32'(under), 32'(m_under));
            chk("level", 32'(level), q.size());
            chk("ready", 32'(ifc.din_ready), 32'(m_ready));
        end
    end

    task automatic push(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        ifc.din = b; ifc.din_valid = 1'b1;
        while (!ifc.din_ready && n < 500) begin @(negedge clk); n++; end
        if (n >= 500) chk("push_timeout", 0, 1);
        @(negedge clk);
        ifc.din_valid = 1'b0;
    endtask

    task automatic wait_strobe();
        int ok;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (strobe) begin ok = 1; break; end
        end
        chk("strobe_wait", ok, 1);
    endtask

    task automatic window(input int n, output logic [255:0] bits, output int ones, output int sat);
        bits = '0; ones = 0; sat = -1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bits[i] = out;
            ones += int'(out);
            if (strobe) sat = i;
        end
    endtask

    task automatic idle_pulse_clear();
        en = 1'b0;
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
    endtask

    task automatic run_sample(input logic [7:0] v, input logic [15:0] pat, input string name);
        logic [255:0] bits;
        int ones, sat;
        idle_pulse_clear();
        push(v);
        en = 1'b1;
        wait_strobe();
        window(16, bits, ones, sat);
`ifndef PDM_DITHER_EN
        chk(name, 32'(bits[15:0]), 32'(pat));
`endif
        en = 1'b0;
        @(negedge clk);
    endtask

    logic [255:0] bits;
    int ones, sat, b0;
    logic [7:0] vals [5];
    logic       rdy  [5];

    initial begin
        ifc.din = '0; ifc.din_valid = 1'b0;

        // Reset values while RST held.
        @(negedge clk);
        chk("rst_out", 32'(out), 0);
        chk("rst_ready", 32'(ifc.din_ready), 1);
        chk("rst_level", 32'(level), 0);
        chk("rst_under", 32'(under), 0);
        chk("rst_strobe", 32'(strobe), 0);
        @(posedge clk); #2 rst = 1'b0;

        // Disabled: no output activity.
        window(20, bits, ones, sat);
        chk("idle_ones", ones, 0);

        // Single-window density patterns (bit i = i-th clock after strobe).
        run_sample(8'h40, 16'h8888, "pat_40");
        run_sample(8'h80, 16'hAAAA, "pat_80");
        run_sample(8'h00, 16'h0000, "pat_00");
        run_sample(8'hFF, 16'hFFFE, "pat_FF");

        // Continuity across a boundary: FF then 00.
        idle_pulse_clear();
        push(8'hFF); push(8'h00);
        en = 1'b1;
        wait_strobe();
        window(16, bits, ones, sat);
        chk("cont_sat", sat, 15);
`ifndef PDM_DITHER_EN
        chk("cont_ones_ff", ones, 15);
`endif
        window(16, bits, ones, sat);
`ifndef PDM_DITHER_EN
        chk("cont_ones_00", ones, 0);
`endif
        en = 1'b0;
        @(negedge clk);

        // Backpressure: five back-to-back writes with EN low.
        idle_pulse_clear();
        chk("bp_under_clr", 32'(under), 0);
        vals = '{8'h00, 8'hFF, 8'h80, 8'h40, 8'hC0};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ifc.din = vals[i]; ifc.din_valid = 1'b1;
            rdy[i] = ifc.din_ready;
        end
        chk("bp_rdy0", 32'(rdy[0]), 1);
        chk("bp_rdy3", 32'(rdy[3]), 1);
        chk("bp_rdy4", 32'(rdy[4]), 0);
        chk("bp_level_full", 32'(level), 4);
        en = 1'b1;
        wait_strobe();
        chk("bp_ready_back", 32'(ifc.din_ready), 1);
        chk("bp_level_3", 32'(level), 3);
        @(negedge clk);
        b0 = int'(out);
        ifc.din_valid = 1'b0;
        chk("bp_level_refill", 32'(level), 4);
        chk("bp_ready_low", 32'(ifc.din_ready), 0);
        window(15, bits, ones, sat);
`ifndef PDM_DITHER_EN
        chk("bp_ones_00", ones + b0, 0);
        window(16, bits, ones, sat); chk("bp_ones_ff", ones, 15);
        window(16, bits, ones, sat); chk("bp_ones_80", ones, 8);
        window(16, bits, ones, sat); chk("bp_ones_40", ones, 4);
        window(16, bits, ones, sat); chk("bp_ones_c0", ones, 12);
`else
        window(64, bits, ones, sat);
`endif
        en = 1'b0;
        @(negedge clk);

        // Underrun: single 0x80 sample, then clear racing a new event.
        idle_pulse_clear();
        push(8'h80);
        en = 1'b1;
        wait_strobe();
        window(16, bits, ones, sat);
`ifndef PDM_DITHER_EN
        chk("ur_pat1", 32'(bits[15:0]), 32'h0000AAAA);
`endif
        chk("ur_no_strobe", sat, -1);
        chk("ur_flag", 32'(under), 1);
        window(15, bits, ones, sat);
`ifndef PDM_DITHER_EN
        chk("ur_pat2", 32'(bits[14:0]), 32'h00002AAA);
`endif
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("ur_set_wins", 32'(under), 1);
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        chk("ur_cleared", 32'(under), 0);
        en = 1'b0;
        @(negedge clk);

        // Long-run density with a constant 0x40 (held through underruns).
        idle_pulse_clear();
        push(8'h40);
        en = 1'b1;
        wait_strobe();
        window(256, bits, ones, sat);
`ifndef PDM_DITHER_EN
        chk("dens_40", ones, 64);
`else
        chk("dens_40_dither", 32'(ones >= 61 && ones <= 67), 1);
`endif
        en = 1'b0;
        @(negedge clk);

        // Asynchronous reset mid-RUN with data queued.
        push(8'hFF); push(8'hFF); push(8'hFF);
        en = 1'b1;
        wait_strobe();
        repeat (5) @(negedge clk);
        chk("pre_rst_level", 32'(level), 2);
        @(posedge clk); #3 rst = 1'b1;
        #1;
        chk("arst_out", 32'(out), 0);
        chk("arst_ready", 32'(ifc.din_ready), 1);
        chk("arst_level", 32'(level), 0);
        chk("arst_under", 32'(under), 0);
        chk("arst_strobe", 32'(strobe), 0);
        en = 1'b0;
        @(posedge clk); #2 rst = 1'b0;
        window(40, bits, ones, sat);
        chk("post_rst_idle", ones, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pdm_modulator.md
Name: pdm_modulator

Overview:
- Transmit-side counterpart of the 1-bit-in / 8-bit-out filter-decimator.
- Accepts 8-bit unsigned PCM samples over a valid/ready interface into a small FIFO.
- Holds each sample for OSR clocks (zero-order-hold interpolation) and drives a first-order delta-sigma modulator that emits one PDM bit per clock on OUT.
- OUT feeds the decimator's IN, closing the loopback path used in system benches.

Parameters:
- OSR, 16: clocks per PCM sample (hold length); must be >= 2.
- FIFO_DEPTH, 4: input FIFO entries; power of 2, >= 2.
- LW, 3: width of FIFO_LEVEL, equal to clog2(FIFO_DEPTH)+1.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- EN  in  1  run enable.
- DIN  in  8  PCM sample, unsigned offset binary; 0x00 = 0% density, 0xFF ~ 100%.
- DIN_VALID  in  1  DIN is valid this cycle.
- DIN_READY  out  1  FIFO can accept a sample.
- OUT  out  1  registered PDM bit.
- SAMPLE_STROBE  out  1  one-cycle pulse when a new sample is loaded from the FIFO.
- UNDERRUN  out  1  sticky flag: a sample boundary passed with the FIFO empty.
- CLR_UNDERRUN  in  1  synchronous clear of UNDERRUN.
- FIFO_LEVEL  out  LW  number of entries held.

Behaviour:
- Reset values: OUT=0, DIN_READY=1, SAMPLE_STROBE=0, UNDERRUN=0, FIFO_LEVEL=0. Internally: acc=0, cur=0x80, phase=0, state=IDLE, FIFO empty.
- FIFO write: occurs when DIN_VALID && DIN_READY.
- DIN_READY: equals (FIFO_LEVEL < FIFO_DEPTH), registered from the post-update level. A full FIFO drops no data because READY is already low.
- Same-cycle read and write: the level is unchanged. On an empty FIFO a same-cycle write does not satisfy a read; the read sees empty.
- FIFO contents persist across EN changes. Only RST flushes the FIFO.
- State IDLE: OUT=0, acc=0, phase=0. On EN=1, go to PRIME.
- State PRIME: wait for FIFO_LEVEL >= 1, then pop the head into cur, pulse SAMPLE_STROBE, set phase=0 and go to RUN. EN=0 returns to IDLE.
- State RUN, every clock:
  - {c, acc_next} = acc + cur + d (9-bit sum), where d = 0 unless the dither option is enabled.
  - acc <= acc_next[7:0]; OUT <= c. OUT therefore lags the modulator sum by one clock.
- RUN phase counter: counts 0..OSR-1 and wraps to 0.
- RUN sample boundary (phase==OSR-1):
  - FIFO non-empty: pop to cur and pulse SAMPLE_STROBE in the same cycle the new cur takes effect.
  - FIFO empty: keep cur (repeat last sample), set UNDERRUN, no strobe.
  - The modulator runs continuously; acc is never reset at a sample boundary.
- Average density: cur/256 per clock over any 256-clock window of constant cur.
- EN=0 in RUN: next clock go to IDLE; OUT=0, acc=0, cur retained. Re-entering RUN via PRIME loads a fresh sample.
- UNDERRUN: set wins over CLR_UNDERRUN when both occur in the same cycle.
- RST mid-operation: immediately forces all reset values regardless of state.

Optional Feature:
- Macro: PDM_DITHER_EN.
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on RST) advances every RUN clock. d = lfsr[0] is used as carry-in, breaking idle tones. Average density becomes ~(cur+0.5)/256. The LFSR holds in IDLE/PRIME.
- Not defined: d = 0, no LFSR logic, and the output is fully deterministic.

Test Plan:
- Reset/idle: assert RST mid-RUN -> OUT=0, DIN_READY=1, FIFO_LEVEL=0, UNDERRUN=0 within the same cycle; EN=0 keeps OUT=0 indefinitely.
- Density: push 0x40 with OSR=16, EN=1 -> after the strobe, OUT repeats 0,0,0,1 (4 ones per 16 clocks); 0x80 -> 0,1 alternation; 0x00 -> all zero; 0xFF -> 15 ones per 16.
- Continuity: push 0xFF then 0x00 -> strobe exactly 16 clocks apart, acc not cleared at the boundary, 15 ones in the first window, 0 ones in the second.
- Backpressure: with EN=0, write 5 samples back-to-back -> DIN_READY=0 after the 4th, FIFO_LEVEL=4, 5th held by source; EN=1 -> samples emerge in order, READY reasserts one clock after the first pop.
- Underrun: single sample 0x80, EN=1 -> at the second boundary UNDERRUN=1, no strobe, 0,1 pattern continues. CLR_UNDERRUN with a simultaneous underrun event -> flag stays 1.
- Loopback: OUT into the filter-decimator IN, constant 0x40 stream -> decimator output settles within +/-2 LSB of its 0x40 equivalent; with PDM_DITHER_EN, the same within +/-3 LSB.
